// File: rtl/otp_seq_ctrl.sv
// OTP macro sequencer: parametrised widths and timing, bit-serial fuse
// programming and optional read-back verify with a mismatch flag.
module otp_seq_ctrl #(
  parameter int unsigned DW        = 8,
  parameter int unsigned AW        = 7,
  parameter int unsigned T_SETUP   = 2,
  parameter int unsigned T_RD      = 4,
  parameter int unsigned T_PGM     = 100,
  parameter int unsigned T_VQ      = 10,
  parameter int unsigned VERIFY_EN = 1
) (
  input  logic                        sys_clk,
  input  logic                        rst,
  input  logic                        i_start,
  input  logic                        i_mode,
  input  logic [AW-1:0]               i_addr,
  input  logic [DW-1:0]               i_wdata,
  output logic                        o_busy,
  output logic                        o_done,
  output logic [DW-1:0]               o_rdata,
  output logic                        o_err,
  output logic                        o_otp_csb,
  output logic                        o_otp_load,
  output logic                        o_otp_strobe,
  output logic                        o_otp_pgenb,
  output logic                        o_otp_vddqsw,
  output logic [AW+$clog2(DW)-1:0]    o_otp_addr,
  input  logic [DW-1:0]               i_otp_q
);

  localparam int unsigned BW   = $clog2(DW);
  localparam int unsigned TM_A = (T_SETUP > T_RD) ? T_SETUP : T_RD;
  localparam int unsigned TM_B = (T_PGM > T_VQ) ? T_PGM : T_VQ;
  localparam int unsigned TMAX = (TM_A > TM_B) ? TM_A : TM_B;
  localparam int unsigned CW   = $clog2(TMAX + 1);

  localparam logic [CW-1:0] SETUP_LAST = CW'(T_SETUP - 1);
  localparam logic [CW-1:0] RD_LAST    = CW'(T_RD - 1);
  localparam logic [CW-1:0] PGM_LAST   = CW'(T_PGM - 1);
  localparam logic [CW-1:0] VQ_LAST    = CW'(T_VQ - 1);
  localparam logic [BW-1:0] BIT_LAST   = BW'(DW - 1);

  typedef enum logic [3:0] {
    IDLE, SETUP, RD_STB, VQ_ON, PGM_STB, PGM_GAP, PGM_SKIP, VQ_OFF, DONE
  } state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [BW-1:0]     bit_q, bit_d;
  logic              mode_q, mode_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [DW-1:0]     wdata_q, wdata_d;
  logic              busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic [DW-1:0]     rdata_q, rdata_d;
  logic              csb_q, csb_d, load_q, load_d, strobe_q, strobe_d;
  logic              pgenb_q, pgenb_d, vddqsw_q, vddqsw_d;
  logic [AW+BW-1:0]  otp_addr_q, otp_addr_d;
  logic              accept, rd_capture;
  logic [BW-1:0]     bit_nx;

  assign bit_nx = bit_q + BW'(1);

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      mode_q     <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
      csb_q      <= 1'b1;
      load_q     <= 1'b0;
      strobe_q   <= 1'b0;
      pgenb_q    <= 1'b1;
      vddqsw_q   <= 1'b0;
      otp_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      mode_q     <= mode_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
      csb_q      <= csb_d;
      load_q     <= load_d;
      strobe_q   <= strobe_d;
      pgenb_q    <= pgenb_d;
      vddqsw_q   <= vddqsw_d;
      otp_addr_q <= otp_addr_d;
    end
  end

  // Next state; every timed state counts cnt from 0 up to its T-1.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + CW'(1);
    bit_d      = bit_q;
    mode_d     = mode_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    accept     = 1'b0;
    rd_capture = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (i_start) begin
          accept  = 1'b1;
          mode_d  = i_mode;
          addr_d  = i_addr;
          wdata_d = i_wdata;
          bit_d   = '0;
          state_d = i_mode ? VQ_ON : SETUP;
        end
      end
      SETUP: if (cnt_q == SETUP_LAST) begin
        cnt_d   = '0;
        state_d = RD_STB;
      end
      RD_STB: if (cnt_q == RD_LAST) begin
        cnt_d      = '0;
        rd_capture = 1'b1;
        state_d    = DONE;
      end
      VQ_ON: if (cnt_q == VQ_LAST) begin
        cnt_d   = '0;
        bit_d   = '0;
        state_d = wdata_q[0] ? PGM_STB : PGM_SKIP;
      end
      PGM_STB: if (cnt_q == PGM_LAST) begin
        cnt_d   = '0;
        state_d = PGM_GAP;
      end
      PGM_GAP, PGM_SKIP: begin
        cnt_d = '0;
        if (bit_q == BIT_LAST) begin
          state_d = VQ_OFF;
        end else begin
          bit_d   = bit_nx;
          state_d = wdata_q[bit_nx] ? PGM_STB : PGM_SKIP;
        end
      end
      VQ_OFF: if (cnt_q == VQ_LAST) begin
        cnt_d   = '0;
        state_d = (VERIFY_EN != 0) ? SETUP : DONE;
      end
      DONE: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // Registered macro pins follow the state being entered.
  always_comb begin
    busy_d     = 1'b1;
    done_d     = 1'b0;
    csb_d      = 1'b1;
    load_d     = 1'b0;
    strobe_d   = 1'b0;
    pgenb_d    = 1'b1;
    vddqsw_d   = 1'b0;
    otp_addr_d = otp_addr_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    if (accept) err_d = 1'b0;
    if (rd_capture) begin
      rdata_d = i_otp_q;
      if (mode_q) err_d = (i_otp_q != wdata_q);
    end
    case (state_d)
      IDLE: busy_d = 1'b0;
      SETUP, RD_STB: begin
        csb_d      = 1'b0;
        load_d     = 1'b1;
        strobe_d   = (state_d == RD_STB);
        otp_addr_d = {addr_d, {BW{1'b0}}};
      end
      VQ_ON, PGM_GAP, PGM_SKIP: begin
        csb_d      = 1'b0;
        vddqsw_d   = 1'b1;
        otp_addr_d = {addr_d, bit_d};
      end
      PGM_STB: begin
        csb_d      = 1'b0;
        vddqsw_d   = 1'b1;
        strobe_d   = 1'b1;
        pgenb_d    = 1'b0;
        otp_addr_d = {addr_d, bit_d};
      end
      VQ_OFF: csb_d = 1'b0;
      DONE: begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
      default: busy_d = 1'b0;
    endcase
  end

  assign o_busy       = busy_q;
  assign o_done       = done_q;
  assign o_rdata      = rdata_q;
  assign o_err        = err_q;
  assign o_otp_csb    = csb_q;
  assign o_otp_load   = load_q;
  assign o_otp_strobe = strobe_q;
  assign o_otp_pgenb  = pgenb_q;
  assign o_otp_vddqsw = vddqsw_q;
  assign o_otp_addr   = otp_addr_q;

endmodule

// File: tb/tb_otp_seq_ctrl.sv
// Bench for otp_seq_ctrl: three instances (no-verify, verify, 16-bit) with
// scoreboards for completions, fuse pulses and supply-switch windows.
module tb_otp_seq_ctrl;

  localparam int unsigned T_SETUP = 2, T_RD = 4, T_PGM = 100, T_VQ = 10, P_T_PGM = 3;

  typedef struct {
    int          done_cyc;
    logic [15:0] rdata;
    logic        err;
  } exp_t;

  logic sys_clk = 1'b0;
  logic rst     = 1'b1;
  int   cyc = 0, checks = 0, errors = 0;

  logic        start [3], mode [3];
  logic [15:0] addr_i [3], wdata_i [3], q_i [3];
  logic        busy [3], done_s [3], err_s [3], csb [3], load [3], strobe [3], pgenb [3], vq [3];
  logic [15:0] rdata_w [3], oaddr_w [3];
  logic [7:0]  rd_a, rd_v;
  logic [15:0] rd_p;
  logic [9:0]  oa_a, oa_v;
  logic [8:0]  oa_p;

  exp_t        sb    [3][$];
  logic [15:0] pq    [3][$];
  int          vql_q [3][$];

  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc <= cyc + 1;

  otp_seq_ctrl #(.VERIFY_EN(0)) u_a (
    .sys_clk(sys_clk), .rst(rst), .i_start(start[0]), .i_mode(mode[0]),
    .i_addr(addr_i[0][6:0]), .i_wdata(wdata_i[0][7:0]), .o_busy(busy[0]), .o_done(done_s[0]),
    .o_rdata(rd_a), .o_err(err_s[0]), .o_otp_csb(csb[0]), .o_otp_load(load[0]),
    .o_otp_strobe(strobe[0]), .o_otp_pgenb(pgenb[0]), .o_otp_vddqsw(vq[0]),
    .o_otp_addr(oa_a), .i_otp_q(q_i[0][7:0]));

  otp_seq_ctrl #(.VERIFY_EN(1)) u_v (
    .sys_clk(sys_clk), .rst(rst), .i_start(start[1]), .i_mode(mode[1]),
    .i_addr(addr_i[1][6:0]), .i_wdata(wdata_i[1][7:0]), .o_busy(busy[1]), .o_done(done_s[1]),
    .o_rdata(rd_v), .o_err(err_s[1]), .o_otp_csb(csb[1]), .o_otp_load(load[1]),
    .o_otp_strobe(strobe[1]), .o_otp_pgenb(pgenb[1]), .o_otp_vddqsw(vq[1]),
    .o_otp_addr(oa_v), .i_otp_q(q_i[1][7:0]));

  otp_seq_ctrl #(.DW(16), .AW(5), .T_PGM(P_T_PGM), .VERIFY_EN(0)) u_p (
    .sys_clk(sys_clk), .rst(rst), .i_start(start[2]), .i_mode(mode[2]),
    .i_addr(addr_i[2][4:0]), .i_wdata(wdata_i[2]), .o_busy(busy[2]), .o_done(done_s[2]),
    .o_rdata(rd_p), .o_err(err_s[2]), .o_otp_csb(csb[2]), .o_otp_load(load[2]),
    .o_otp_strobe(strobe[2]), .o_otp_pgenb(pgenb[2]), .o_otp_vddqsw(vq[2]),
    .o_otp_addr(oa_p), .i_otp_q(q_i[2]));

  assign rdata_w[0] = 16'(rd_a);
  assign rdata_w[1] = 16'(rd_v);
  assign rdata_w[2] = rd_p;
  assign oaddr_w[0] = 16'(oa_a);
  assign oaddr_w[1] = 16'(oa_v);
  assign oaddr_w[2] = 16'(oa_p);

  task automatic chk(input string tag, input int inst, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s[%0d]: observed %0h expected %0h", tag, inst, obs, exp_v);
    end
  endtask

  // Reference cycle count from accept to done for a program operation.
  function automatic int prog_lat(input logic [15:0] w, input int dw, input int tp, input bit ver);
    int l;
    l = int'(T_VQ);
    for (int b = 0; b < dw; b++) l += w[b] ? tp + 1 : 1;
    return l + int'(T_VQ) + (ver ? int'(T_SETUP + T_RD) : 0);
  endfunction

  task automatic go(input int g, input logic md, input logic [15:0] ad, input logic [15:0] wd,
                    input logic [15:0] er, input logic ee);
    exp_t e;
    int dw, bw, tp;
    dw = (g == 2) ? 16 : 8;
    bw = (g == 2) ? 4 : 3;
    tp = (g == 2) ? int'(P_T_PGM) : int'(T_PGM);
    @(negedge sys_clk);
    mode[g] = md; addr_i[g] = ad; wdata_i[g] = wd; start[g] = 1'b1;
    e.done_cyc = cyc + 1 + (md ? prog_lat(wd, dw, tp, g == 1) : int'(T_SETUP + T_RD));
    e.rdata = er;
    e.err = ee;
    sb[g].push_back(e);
    if (md) begin
      for (int b = 0; b < dw; b++) if (wd[b]) pq[g].push_back(16'((32'(ad) << bw) | 32'(b)));
      vql_q[g].push_back(prog_lat(wd, dw, tp, 1'b0) - int'(T_VQ));
    end
    @(negedge sys_clk);
    start[g] = 1'b0;
  endtask

  task automatic wait_done(input int g, input int max_cyc);
    int n;
    n = 0;
    while (sb[g].size() != 0 && n < max_cyc) begin
      @(negedge sys_clk);
      n++;
    end
    chk("done_timeout", g, 32'(sb[g].size()), 32'h0);
    repeat (3) @(negedge sys_clk);
  endtask

  // Per-instance monitors: done scoreboard, pulse addresses/widths, supply window.
  for (genvar g = 0; g < 3; g++) begin : g_mon
    localparam int unsigned TP = (g == 2) ? P_T_PGM : T_PGM;
    int          pw = 0, vql = 0, pulses = 0, dones = 0, exp_l;
    logic        pg_prev = 1'b1, vq_prev = 1'b0, first = 1'b0;
    logic [15:0] exp_a;
    exp_t        e;
    initial forever begin
      @(negedge sys_clk);
      if (rst) begin
        pg_prev = 1'b1; vq_prev = 1'b0; pw = 0; first = 1'b0;
      end else begin
        if (vq[g] !== vq_prev) chk("strobe_at_vq_edge", g, 32'(strobe[g]), 32'h0);
        if (vq[g]) begin
          if (!vq_prev) begin vql = 0; first = 1'b1; end
          vql++;
        end else if (vq_prev) begin
          if (vql_q[g].size() != 0) exp_l = vql_q[g].pop_front(); else exp_l = -1;
          chk("vq_high_len", g, 32'(vql), 32'(exp_l));
        end
        if (!pgenb[g]) begin
          chk("pgenb_needs_vq_strobe", g, 32'({vq[g], strobe[g]}), 32'h3);
          if (pg_prev) begin
            pulses++;
            pw = 0;
            if (first) begin
              chk("vq_margin_before", g, 32'(vql - 1), 32'(T_VQ));
              first = 1'b0;
            end
            if (pq[g].size() != 0) exp_a = pq[g].pop_front(); else exp_a = 16'hFFFF;
            chk("pulse_addr", g, 32'(oaddr_w[g]), 32'(exp_a));
          end
          pw++;
        end else if (!pg_prev) begin
          chk("pulse_width", g, 32'(pw), 32'(TP));
        end
        if (done_s[g]) begin
          dones++;
          if (sb[g].size() != 0) e = sb[g].pop_front();
          else begin e.done_cyc = -1; e.rdata = 16'hDEAD; e.err = 1'b1; end
          chk("done_cycle", g, 32'(cyc), 32'(e.done_cyc));
          chk("rdata", g, 32'(rdata_w[g]), 32'(e.rdata));
          chk("err", g, 32'(err_s[g]), 32'(e.err));
          chk("busy_csb_at_done", g, 32'({busy[g], csb[g]}), 32'h1);
        end
        pg_prev = pgenb[g];
        vq_prev = vq[g];
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int p0, d0, n;
    for (int i = 0; i < 3; i++) begin
      start[i] = 1'b0; mode[i] = 1'b0; addr_i[i] = '0; wdata_i[i] = '0; q_i[i] = '0;
    end
    repeat (2) @(posedge sys_clk);
    @(negedge sys_clk);
    for (int g = 0; g < 3; g++) begin
      chk("reset_ctrl", g, 32'({busy[g], done_s[g], err_s[g], csb[g], load[g], strobe[g],
                                pgenb[g], vq[g]}), 32'h12);
      chk("reset_rdata", g, 32'(rdata_w[g]), 32'h0);
      chk("reset_addr", g, 32'(oaddr_w[g]), 32'h0);
    end
    rst = 1'b0;

    // Plain read: 6-edge latency, strobe in the last four cycles.
    q_i[0] = 16'h003C;
    go(0, 1'b0, 16'h0A, 16'h0, 16'h3C, 1'b0);
    chk("rd_setup", 0, 32'({busy[0], csb[0], load[0], strobe[0]}), 32'hA);
    chk("rd_addr", 0, 32'(oaddr_w[0]), 32'h50);
    repeat (2) @(negedge sys_clk);
    chk("rd_strobe_first", 0, 32'({csb[0], load[0], strobe[0]}), 32'h3);
    repeat (3) @(negedge sys_clk);
    chk("rd_strobe_last", 0, 32'({done_s[0], strobe[0], csb[0]}), 32'h2);
    wait_done(0, 20);

    // Program A5 without verify: four fuse pulses, rdata untouched.
    p0 = g_mon[0].pulses;
    go(0, 1'b1, 16'h05, 16'hA5, 16'h3C, 1'b0);
    wait_done(0, 600);
    chk("pgm_a5_pulses", 0, 32'(g_mon[0].pulses - p0), 32'd4);
    chk("pgm_a5_pq_drained", 0, 32'(pq[0].size()), 32'h0);

    // All-zero word: no pulses, supply window still runs.
    p0 = g_mon[0].pulses;
    go(0, 1'b1, 16'h05, 16'h00, 16'h3C, 1'b0);
    wait_done(0, 100);
    chk("pgm_00_pulses", 0, 32'(g_mon[0].pulses - p0), 32'h0);
    chk("pgm_00_vq_seen", 0, 32'(vql_q[0].size()), 32'h0);

    // Verify pass, verify fail, then a read clears err.
    q_i[1] = 16'h00A5;
    go(1, 1'b1, 16'h05, 16'hA5, 16'hA5, 1'b0);
    wait_done(1, 600);
    q_i[1] = 16'h00A4;
    go(1, 1'b1, 16'h05, 16'hA5, 16'hA4, 1'b1);
    wait_done(1, 600);
    chk("err_held_idle", 1, 32'(err_s[1]), 32'h1);
    go(1, 1'b0, 16'h01, 16'h0, 16'hA4, 1'b0);
    wait_done(1, 20);

    // Reset during the second fuse pulse aborts cleanly.
    p0 = g_mon[0].pulses;
    go(0, 1'b1, 16'h05, 16'hA5, 16'h3C, 1'b0);
    n = 0;
    while (g_mon[0].pulses - p0 < 2 && n < 400) begin
      @(negedge sys_clk);
      n++;
    end
    chk("second_pulse_seen", 0, 32'(g_mon[0].pulses - p0), 32'd2);
    repeat (5) @(negedge sys_clk);
    chk("mid_pulse", 0, 32'({vq[0], strobe[0], pgenb[0]}), 32'h6);
    rst = 1'b1;
    sb[0].delete(); pq[0].delete(); vql_q[0].delete();
    @(negedge sys_clk);
    chk("rst_abort", 0, 32'({busy[0], done_s[0], vq[0], strobe[0], pgenb[0], csb[0]}), 32'h3);
    @(negedge sys_clk);
    rst = 1'b0;
    repeat (3) @(negedge sys_clk);
    q_i[0] = 16'h005A;
    go(0, 1'b0, 16'h7F, 16'h0, 16'h5A, 1'b0);
    wait_done(0, 20);

    // 16-bit instance: pulses at bits 0 and 15 only; start while busy ignored.
    p0 = g_mon[2].pulses;
    d0 = g_mon[2].dones;
    go(2, 1'b1, 16'h13, 16'h8001, 16'h0, 1'b0);
    repeat (5) @(negedge sys_clk);
    chk("p_busy", 2, 32'(busy[2]), 32'h1);
    mode[2] = 1'b0; start[2] = 1'b1;
    @(negedge sys_clk);
    start[2] = 1'b0;
    wait_done(2, 100);
    repeat (20) @(negedge sys_clk);
    chk("p_single_done", 2, 32'(g_mon[2].dones - d0), 32'h1);
    chk("p_pulses", 2, 32'(g_mon[2].pulses - p0), 32'h2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/otp_seq_ctrl.md
Name: otp_seq_ctrl

Overview:
- Parametrised next-generation OTP macro sequencer.
- Sits between the host/register-file side (start/mode/addr/data) and the OTP macro pins.
- Generalises the fixed 8-bit controller in four ways: data width, address width and all timing intervals are parameters; programming is bit-serial (one fuse per strobe); program-then-verify is optional with a mismatch flag.

Parameters:
- DW, 8, OTP word width (bits, power of 2, >=2)
- AW, 7, word address width
- T_SETUP, 2, cycles csb low / load high before the first strobe
- T_RD, 4, read strobe width in cycles
- T_PGM, 100, program strobe width in cycles
- T_VQ, 10, settle cycles after vddqsw rises and after it falls
- VERIFY_EN, 1, 1 = read back after program and compare
- BW, $clog2(DW), bit-index width (derived, not overridable)

Ports:
- sys_clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- i_start  in  1  one-cycle request, sampled only in IDLE
- i_mode  in  1  0 = read, 1 = program; latched with i_start
- i_addr  in  AW  word address; latched with i_start
- i_wdata  in  DW  program data; latched with i_start
- o_busy  out  1  high from the i_start-accepting edge until DONE
- o_done  out  1  one-cycle completion pulse
- o_rdata  out  DW  last captured read word
- o_err  out  1  verify mismatch on last program; cleared on next accepted start
- o_otp_csb  out  1  macro select, active low
- o_otp_load  out  1  sense-amp load enable
- o_otp_strobe  out  1  read/program strobe
- o_otp_pgenb  out  1  program enable, active low
- o_otp_vddqsw  out  1  program supply switch
- o_otp_addr  out  AW+BW  {word addr, bit index}
- i_otp_q  in  DW  macro read data

Behaviour:
- Reset values: busy=0, done=0, rdata=0, err=0, csb=1, load=0, strobe=0, pgenb=1, vddqsw=0, addr=0, state=IDLE.
- Reset has priority over every other event. Asserting rst mid-operation forces the reset values at the next edge: vddqsw drops, strobe drops, no done pulse.
- IDLE: on i_start=1, latch mode/addr/wdata, clear err, and set busy at the same edge. Go to SETUP for a read, or VQ_ON for a program.
- i_start while busy or in DONE is ignored (no queueing).
- SETUP (T_SETUP cycles): csb=0, load=1, strobe=0, addr={addr,0}. Then go to RD_STB.
- RD_STB (T_RD cycles): csb=0, load=1, strobe=1.
  - On the last cycle's edge, capture rdata <= i_otp_q.
  - If this is a verify read, also set err = (i_otp_q != wdata).
  - Then go to DONE.
- Read latency: with E0 as the accepting edge, done is high in the cycle starting T_SETUP+T_RD edges after E0. Defaults: 6 edges.
- VQ_ON (T_VQ cycles): vddqsw=1, csb=0, pgenb=1, bit index=0.
- PGM_BIT, per bit index b = 0..DW-1, LSB first:
  - If wdata[b]=1: PGM_STB for T_PGM cycles with pgenb=0, strobe=1, addr={addr,b}; then one PGM_GAP cycle with pgenb=1, strobe=0.
  - If wdata[b]=0: one skip cycle with no strobe.
  - After b=DW-1, go to VQ_OFF.
- VQ_OFF (T_VQ cycles): vddqsw=0, pgenb=1, strobe=0. Then go to SETUP (verify read) if VERIFY_EN, else DONE.
- Verify reads always use bit index 0 in addr.
- DONE (1 cycle): done=1, busy=0, csb=1, load=0. Then go to IDLE.
- Invariants:
  - strobe never high while vddqsw is changing.
  - pgenb=0 only while vddqsw=1 and strobe=1.
  - Exactly one pgenb=0 interval per '1' bit.
- All-zero wdata: no strobes; full VQ_ON/VQ_OFF sequence still runs.
- All-ones wdata: DW strobes.
- Counters are sized to the largest of T_SETUP, T_RD, T_PGM, T_VQ. Each T_* parameter must be >= 1.

Test Plan:
- Read: rst 2 cycles, i_mode=0, i_addr=7'h0A, i_otp_q held 8'h3C, pulse i_start → csb low 6 cycles, strobe high cycles 3-6, o_rdata=8'h3C, o_done high exactly 6 edges after start, busy low on the done cycle.
- Program 8'hA5 at addr 7'h05, VERIFY_EN=0 → exactly 4 pgenb-low pulses, each 100 cycles, o_otp_addr = {05,0},{05,2},{05,5},{05,7}; vddqsw high throughout with 10-cycle margins before and after; then done.
- Program 8'h00 → zero strobes, vddqsw pulse still present, done asserted, err=0.
- Verify, VERIFY_EN=1: program 8'hA5 with i_otp_q=8'hA5 → err=0, rdata=8'hA5. Repeat with i_otp_q=8'hA4 → err=1, rdata=8'hA4.
- Reset mid-program: assert rst during the second PGM_STB → next edge gives vddqsw=0, strobe=0, pgenb=1, busy=0, no done pulse; a fresh read afterwards completes normally.
- Parametric: DW=16, AW=5, T_PGM=3 → 16 bit steps, BW=4, addr width 9; program 16'h8001 gives strobes only at bit indices 0 and 15. Also pulse i_start during busy → ignored (single done only).
